sram_stream_reader: RTL and testbench

- Read-side initiator for the team's single-port synchronous SRAM, which has 1-cycle registered read latency and holds its output on non-read cycles.
- On a start pulse it reads a contiguous run of words beginning at a base address and streams them out over a valid/ready interface, in order.
- Feeds the VGA pixel pipeline and line buffers.
- Absorbs downstream backpressure with an internal 4-entry FIFO, so no SRAM read data is ever lost.

---
 rtl/sram_stream_reader.sv | 165 ++++++++++++++++
 tb/tb_sram_stream_reader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : sram_stream_reader
// Brief    : Streams a contiguous run of SRAM words out over valid/ready,
//            using a 4-entry FIFO and read credits to absorb backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module sram_stream_reader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH-1:0]  i_base,
    input  logic [COUNT_WIDTH-1:0] i_count,
    output logic [ADDR_WIDTH-1:0]  o_sram_addr,
    output logic                   o_sram_write,
    input  logic [DATA_WIDTH-1:0]  i_sram_data,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                   issue_q, issue_d, issue_last_q, issue_last_d;
    logic                   rd_q, rd_d, rd_last_q, rd_last_d;
    logic [DATA_WIDTH-1:0]  fifo_data_q [4];
    logic [DATA_WIDTH-1:0]  fifo_data_d [4];
    logic [3:0]             fifo_last_q, fifo_last_d;
    logic [1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]             fifo_cnt_q, fifo_cnt_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic                   w_push, w_pop, w_credit;

    always_comb begin
        // The SRAM returns data the cycle after the address stage, so the
        // read pipeline is issue (address out) then rd (data on the bus).
        w_push   = rd_q;
        w_pop    = (fifo_cnt_q != 3'd0) && i_ready;
        w_credit = (fifo_cnt_q + {2'b00, issue_q} + {2'b00, rd_q}) < 3'd4;

        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (w_push) begin
            fifo_data_d[wr_ptr_q] = i_sram_data;
            fifo_last_d[wr_ptr_q] = rd_last_q;
            wr_ptr_d              = wr_ptr_q + 2'd1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        fifo_cnt_d = fifo_cnt_q + {2'b00, w_push} - {2'b00, w_pop};

        rd_d         = issue_q;
        rd_last_d    = issue_last_q;
        issue_d      = 1'b0;
        issue_last_d = 1'b0;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        state_d      = state_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_count == '0) begin
                        // Empty run still passes one idle drain cycle before done.
                        state_d = S_DRAIN;
                    end else begin
                        addr_d       = i_base;
                        issue_d      = 1'b1;
                        issue_last_d = (i_count == COUNT_WIDTH'(1));
                        remaining_d  = i_count - COUNT_WIDTH'(1);
                        state_d      = (i_count == COUNT_WIDTH'(1)) ? S_DRAIN : S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if ((remaining_q != '0) && w_credit) begin
                    addr_d       = addr_q + ADDR_WIDTH'(1);
                    issue_d      = 1'b1;
                    issue_last_d = (remaining_q == COUNT_WIDTH'(1));
                    remaining_d  = remaining_q - COUNT_WIDTH'(1);
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((fifo_cnt_d == 3'd0) && !issue_q && !rd_q) begin
                    state_d = S_FINISH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            issue_q      <= 1'b0;
            issue_last_q <= 1'b0;
            rd_q         <= 1'b0;
            rd_last_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            issue_q      <= issue_d;
            issue_last_q <= issue_last_d;
            rd_q         <= rd_d;
            rd_last_q    <= rd_last_d;
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= fifo_data_d[i];
            end
            fifo_last_q  <= fifo_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_sram_addr  = addr_q;
    assign o_sram_write = 1'b0;
    assign o_valid      = (fifo_cnt_q != 3'd0);
    assign o_data       = fifo_data_q[rd_ptr_q];
    assign o_last       = o_valid && fifo_last_q[rd_ptr_q];
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_stream_reader
// Brief    : Self-checking bench for sram_stream_reader against a word-queue
//            reference built from memory contents and the run parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_stream_reader;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          i_rst, i_start, i_ready;
    logic [AW-1:0] i_base, o_sram_addr;
    logic [CW-1:0] i_count;
    logic [DW-1:0] sram_rdata, o_data;
    logic          o_sram_write, o_valid, o_last, o_busy, o_done;

    logic [DW-1:0] mem [256];
    int            tests  = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    // Single-port SRAM with one-cycle registered read.
    always @(posedge clk) sram_rdata <= mem[o_sram_addr];

    sram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) u_dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_base       (i_base),
        .i_count      (i_count),
        .o_sram_addr  (o_sram_addr),
        .o_sram_write (o_sram_write),
        .i_sram_data  (sram_rdata),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c >= 20 && c < 30) ? 1'b0 : ((c % 4 == 0) || (c % 4 == 3));
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One run: start in cycle 0, sample each cycle on the falling edge.
    task automatic run_stream(input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                              input int mode, input int busy_start_cyc, input int abort_after);
        logic [DW-1:0] exp_q [$];
        int            got = 0, done_cyc = -1, first_valid = -1, last_xfer = -1;
        int            max_ahead = 0, ahead;
        bit            held = 0, addr_moved = 0, finished = 0, aborted = 0;
        logic [DW-1:0] held_data;
        logic          held_last;
        logic [AW-1:0] addr0;

        for (int i = 0; i < int'(cnt); i++) exp_q.push_back(mem[AW'(int'(base) + i)]);

        @(posedge clk); #1;
        i_base  = base;
        i_count = cnt;
        i_start = 1'b1;
        i_ready = ready_for(mode, 0);
        for (int c = 0; c < 1500 && !finished; c++) begin
            @(negedge clk);
            if (c == 0) addr0 = o_sram_addr;
            else if (o_sram_addr != addr0) addr_moved = 1;
            if (c == 1) check("busy_after_start", o_busy, 1);
            if (held) check("hold_stable", {o_valid, o_last, o_data}, {1'b1, held_last, held_data});
            held      = o_valid && !i_ready;
            held_data = o_data;
            held_last = o_last;
            if (o_valid && first_valid < 0) first_valid = c;
            if (c >= 1 && cnt != 0) begin
                ahead = int'(AW'(o_sram_addr - base)) + 1 - got;
                if (ahead > max_ahead) max_ahead = ahead;
            end
            if (o_valid && i_ready) begin
                if (got < exp_q.size()) begin
                    check("data", o_data, exp_q[got]);
                    check("last", o_last, (got == int'(cnt) - 1));
                end else begin
                    check("extra_word", got, exp_q.size());
                end
                got++;
                last_xfer = c;
            end
            if (o_done) begin
                done_cyc = c;
                check("busy_at_done", o_busy, 1);
                finished = 1;
            end
            if (abort_after >= 0 && got == abort_after) begin
                #1 i_rst = 1'b1;
                #1 check("rst_async_outputs",
                         {o_valid, o_last, o_busy, o_done, o_sram_write, o_sram_addr}, 0);
                aborted  = 1;
                finished = 1;
            end
            if (!finished) begin
                @(posedge clk); #1;
                i_start = (c + 1 == busy_start_cyc);
                if (i_start) begin
                    i_base  = ~base;
                    i_count = 3;
                end
                i_ready = ready_for(mode, c + 1);
            end
        end
        i_start = 1'b0;
        if (aborted) return;

        check("done_seen", finished, 1);
        check("word_count", got, cnt);
        if (cnt == 0) begin
            check("zero_no_valid", first_valid, -1);
            check("zero_addr_held", addr_moved, 0);
            check("zero_done_cycle", done_cyc, 2);
        end else begin
            check("done_after_last", done_cyc, last_xfer + 1);
            check("max_ahead_le4", max_ahead <= 4, 1);
            if (mode == 0) begin
                check("first_valid_cycle", first_valid, 3);
                check("no_bubbles", last_xfer, 2 + int'(cnt));
            end
        end
    endtask

    initial begin
        bit bad;
        i_rst   = 1'b0;
        i_start = 1'b0;
        i_base  = '0;
        i_count = '0;
        i_ready = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = DW'(a);
        #1 i_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {o_valid, o_last, o_busy, o_done, o_sram_write, o_sram_addr}, 0);
        i_rst = 1'b0;

        run_stream(8'h10, 5, 0, -1, -1);
        for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
        run_stream(8'h20, 8, 1, -1, -1);
        run_stream(8'hFE, 4, 0, -1, -1);
        run_stream(8'h40, 0, 0, -1, -1);
        run_stream(8'h50, 6, 0, 3, -1);
        run_stream(8'h60, 3, 0, -1, -1);
        run_stream(8'h70, 8, 0, -1, 3);

        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_done || o_valid) bad = 1;
        end
        check("no_done_after_abort", bad, 0);
        run_stream(8'h80, 2, 0, -1, -1);

        for (int k = 0; k < 8; k++)
            run_stream(AW'($urandom), CW'($urandom_range(1, 20)), 2, -1, -1);
        run_stream(8'h00, 256, 2, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
